// File: rtl/lcd_pkg.sv
// Shared types and constants for the HD44780 character-LCD controller.
// Holds the FSM state encoding, the power-up init table and the timing helpers.
package lcd_pkg;

    typedef enum logic [2:0] {
        PWRUP = 3'd0,
        SETUP = 3'd1,
        PULSE = 3'd2,
        HOLD  = 3'd3,
        WAIT  = 3'd4,
        IDLE  = 3'd5
    } state_t;

    localparam int INIT_LEN = 4;
    localparam int IDX_W    = $clog2(INIT_LEN);

    // Function set 8-bit/2-line, display on, clear, entry mode increment.
    // Entry 0 sits in the low byte.
    localparam logic [INIT_LEN-1:0][7:0] INIT_ROM = {8'h06, 8'h01, 8'h0C, 8'h38};

    // Clear (0x01) and return-home (0x02/0x03) need the long execution time.
    function automatic logic is_long_cmd(input logic rs, input logic [7:0] data);
        return !rs && (data[7:2] == 6'd0) && (data[1:0] != 2'd0);
    endfunction

    // Counter reload value for a dwell of t cycles; zero is treated as one cycle.
    function automatic int dwell_m1(input int t);
        return (t <= 1) ? 0 : t - 1;
    endfunction

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/lcd_timer.sv
// Loadable down-counter shared by every FSM state.
// o_done is high while the count is zero; a load always wins over counting.
module lcd_timer
    import lcd_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         i_load,
    input  logic [W-1:0] i_value,
    output logic         o_done
);

    logic [W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (i_load) begin
            r_count <= i_value;
        end else if (r_count != '0) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_done = (r_count == '0);

endmodule

// File: rtl/lcd_ctrl.sv
// HD44780 bus controller: power-up wait, fixed init sequence, then one byte
// per valid/ready handshake, each driven as a timed RS/EN/DATA write cycle.
module lcd_ctrl
    import lcd_pkg::*;
#(
    parameter int T_PWRUP = 750000,
    parameter int T_SETUP = 3,
    parameter int T_EN    = 12,
    parameter int T_HOLD  = 3,
    parameter int T_SHORT = 2000,
    parameter int T_LONG  = 82000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    input  logic       cmd_rs,
    input  logic [7:0] cmd_data,
    output logic       cmd_ready,
    output logic       init_done,
    input  logic       ctl_on,
    input  logic       ctl_blon,
    output logic       lcd_on,
    output logic       lcd_blon,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       lcd_en,
    output logic [7:0] lcd_data
);

    localparam int T_MAX = max2(max2(max2(T_PWRUP, T_SETUP), max2(T_EN, T_HOLD)),
                                max2(T_SHORT, T_LONG));
    localparam int CW    = $clog2(T_MAX) + 1;

    localparam logic [CW-1:0] D_PWRUP = CW'(dwell_m1(T_PWRUP));
    localparam logic [CW-1:0] D_SETUP = CW'(dwell_m1(T_SETUP));
    localparam logic [CW-1:0] D_EN    = CW'(dwell_m1(T_EN));
    localparam logic [CW-1:0] D_HOLD  = CW'(dwell_m1(T_HOLD));
    localparam logic [CW-1:0] D_SHORT = CW'(dwell_m1(T_SHORT));
    localparam logic [CW-1:0] D_LONG  = CW'(dwell_m1(T_LONG));

    state_t            r_state;
    state_t            w_state_next;
    logic              w_load;
    logic [CW-1:0]     w_load_val;
    logic              w_tmr_load;
    logic [CW-1:0]     w_tmr_val;
    logic              w_done;

    logic [IDX_W-1:0]  r_init_idx;
    logic [IDX_W-1:0]  w_init_idx_next;
    logic              r_init_done;
    logic              w_init_done_next;
    logic              r_rs;
    logic              w_rs_next;
    logic [7:0]        r_data;
    logic [7:0]        w_data_next;
    logic              r_en;
    logic              w_en_next;
    logic              r_ready;
    logic              w_ready_next;
    logic              r_on;
    logic              r_blon;
    logic              w_last_entry;

    // Reset reloads the power-up wait so PWRUP dwell starts from the reset edge.
    assign w_tmr_load = rst | w_load;
    assign w_tmr_val  = rst ? D_PWRUP : w_load_val;

    lcd_timer #(
        .W (CW)
    ) u_timer (
        .clk     (clk),
        .i_load  (w_tmr_load),
        .i_value (w_tmr_val),
        .o_done  (w_done)
    );

    assign w_last_entry = (r_init_idx == IDX_W'(INIT_LEN - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= PWRUP;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_load_val   = D_SETUP;
        case (r_state)
            PWRUP: if (w_done) begin
                w_state_next = SETUP;
                w_load       = 1'b1;
                w_load_val   = D_SETUP;
            end
            SETUP: if (w_done) begin
                w_state_next = PULSE;
                w_load       = 1'b1;
                w_load_val   = D_EN;
            end
            PULSE: if (w_done) begin
                w_state_next = HOLD;
                w_load       = 1'b1;
                w_load_val   = D_HOLD;
            end
            HOLD: if (w_done) begin
                w_state_next = WAIT;
                w_load       = 1'b1;
                w_load_val   = is_long_cmd(r_rs, r_data) ? D_LONG : D_SHORT;
            end
            WAIT: if (w_done) begin
                if (r_init_done || w_last_entry) begin
                    w_state_next = IDLE;
                end else begin
                    w_state_next = SETUP;
                    w_load       = 1'b1;
                    w_load_val   = D_SETUP;
                end
            end
            IDLE: if (cmd_valid) begin
                w_state_next = SETUP;
                w_load       = 1'b1;
                w_load_val   = D_SETUP;
            end
            default: w_state_next = PWRUP;
        endcase
    end

    // Every output is registered from the next state, so pins change together.
    always_comb begin
        w_rs_next        = r_rs;
        w_data_next      = r_data;
        w_init_idx_next  = r_init_idx;
        w_init_done_next = r_init_done;
        w_en_next        = (w_state_next == PULSE);
        w_ready_next     = (w_state_next == IDLE);
        case (r_state)
            PWRUP: if (w_done) begin
                w_rs_next   = 1'b0;
                w_data_next = INIT_ROM[0];
            end
            WAIT: if (w_done && !r_init_done) begin
                if (w_last_entry) begin
                    w_init_done_next = 1'b1;
                end else begin
                    w_init_idx_next = r_init_idx + 1'b1;
                    w_data_next     = INIT_ROM[r_init_idx + 1'b1];
                end
            end
            IDLE: if (cmd_valid) begin
                w_rs_next   = cmd_rs;
                w_data_next = cmd_data;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_init_idx  <= '0;
            r_init_done <= 1'b0;
            r_rs        <= 1'b0;
            r_data      <= 8'h00;
            r_en        <= 1'b0;
            r_ready     <= 1'b0;
            r_on        <= 1'b0;
            r_blon      <= 1'b0;
        end else begin
            r_init_idx  <= w_init_idx_next;
            r_init_done <= w_init_done_next;
            r_rs        <= w_rs_next;
            r_data      <= w_data_next;
            r_en        <= w_en_next;
            r_ready     <= w_ready_next;
            r_on        <= ctl_on;
            r_blon      <= ctl_blon;
        end
    end

    assign cmd_ready = r_ready;
    assign init_done = r_init_done;
    assign lcd_on    = r_on;
    assign lcd_blon  = r_blon;
    assign lcd_rs    = r_rs;
    assign lcd_rw    = 1'b0;
    assign lcd_en    = r_en;
    assign lcd_data  = r_data;

endmodule

// File: tb/tb_lcd_ctrl.sv
// Directed bench for lcd_ctrl with short timing parameters; each scenario task
// drives stimulus and compares outputs against hand-computed cycle positions.
module tb_lcd_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_rs = 1'b0;
    logic [7:0] cmd_data = 8'h00;
    logic       ctl_on = 1'b0;
    logic       ctl_blon = 1'b0;
    logic       cmd_ready, init_done, lcd_on, lcd_blon, lcd_rs, lcd_rw, lcd_en;
    logic [7:0] lcd_data;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    lcd_ctrl #(
        .T_PWRUP (10),
        .T_SETUP (2),
        .T_EN    (3),
        .T_HOLD  (2),
        .T_SHORT (5),
        .T_LONG  (20)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_rs    (cmd_rs),
        .cmd_data  (cmd_data),
        .cmd_ready (cmd_ready),
        .init_done (init_done),
        .ctl_on    (ctl_on),
        .ctl_blon  (ctl_blon),
        .lcd_on    (lcd_on),
        .lcd_blon  (lcd_blon),
        .lcd_rs    (lcd_rs),
        .lcd_rw    (lcd_rw),
        .lcd_en    (lcd_en),
        .lcd_data  (lcd_data)
    );

    // Called #1 after the last reset edge; edge n below is the n-th edge with rst low.
    task automatic run_init(input string tag, input bit toggle_ctl, input bit poke_valid);
        int         exp_rise [4] = '{12, 24, 36, 63};
        logic [7:0] exp_byte [4] = '{8'h38, 8'h0C, 8'h01, 8'h06};
        int         rises = 0;
        int         ready_at = 0;
        logic       prev_en = 1'b0;
        logic       prev_on, prev_blon;
        for (int n = 1; n <= 80; n++) begin
            if (poke_valid) begin
                cmd_valid = (n <= 72);
                cmd_rs    = 1'b1;
                cmd_data  = 8'h55;
            end
            prev_on   = ctl_on;
            prev_blon = ctl_blon;
            @(posedge clk); #1;
            if (toggle_ctl) begin
                total++;
                if (lcd_on !== prev_on || lcd_blon !== prev_blon) begin
                    bad++;
                    $display("FAIL %s_ctl edge %0d: on/blon=%b%b expected %b%b", tag, n,
                             lcd_on, lcd_blon, prev_on, prev_blon);
                end
                ctl_on   = (n % 3 == 0);
                ctl_blon = (n % 2 == 0);
            end
            if (lcd_en === 1'b1 && prev_en === 1'b0) begin
                total++;
                if (rises >= 4) begin
                    bad++;
                    $display("FAIL %s_extra_en edge %0d: pulse %0d expected only 4", tag, n, rises + 1);
                end else if (n != exp_rise[rises] || lcd_data !== exp_byte[rises] || lcd_rs !== 1'b0) begin
                    bad++;
                    $display("FAIL %s_en%0d: edge %0d data %h rs %b expected edge %0d data %h rs 0",
                             tag, rises, n, lcd_data, lcd_rs, exp_rise[rises], exp_byte[rises]);
                end
                rises++;
            end
            prev_en = lcd_en;
            if (ready_at == 0 && (cmd_ready === 1'b1 || init_done === 1'b1)) begin
                ready_at = n;
                total++;
                if (cmd_ready !== 1'b1 || init_done !== 1'b1) begin
                    bad++;
                    $display("FAIL %s_together edge %0d: ready=%b init_done=%b expected 1 1",
                             tag, n, cmd_ready, init_done);
                end
            end
        end
        cmd_valid = 1'b0;
        total++;
        if (rises != 4) begin
            bad++;
            $display("FAIL %s_en_count: %0d pulses expected 4", tag, rises);
        end
        total++;
        if (ready_at != 73) begin
            bad++;
            $display("FAIL %s_ready_edge: ready rose at edge %0d expected 73", tag, ready_at);
        end
        total++;
        if (cmd_ready !== 1'b1 || lcd_data !== 8'h06 || lcd_rs !== 1'b0 || lcd_rw !== 1'b0) begin
            bad++;
            $display("FAIL %s_idle: ready=%b data=%h rs=%b rw=%b expected 1 06 0 0", tag,
                     cmd_ready, lcd_data, lcd_rs, lcd_rw);
        end
        $display("%s: init sequence observed, %0d EN pulses, ready at edge %0d", tag, rises, ready_at);
    endtask

    task automatic test_reset();
        ctl_on   = 1'b1;
        ctl_blon = 1'b1;
        rst      = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            total++;
            if ({cmd_ready, init_done, lcd_on, lcd_blon, lcd_rs, lcd_rw, lcd_en, lcd_data} !== 15'd0) begin
                bad++;
                $display("FAIL reset_outputs cycle %0d: rdy=%b done=%b on=%b blon=%b rs=%b rw=%b en=%b data=%h expected all 0",
                         i, cmd_ready, init_done, lcd_on, lcd_blon, lcd_rs, lcd_rw, lcd_en, lcd_data);
            end
        end
        rst = 1'b0;
        $display("test_reset: outputs held at 0 for 3 reset cycles");
    endtask

    task automatic test_init_ctl();
        run_init("init", 1'b1, 1'b0);
    endtask

    task automatic test_data_write();
        total++;
        if (cmd_ready !== 1'b1) begin
            bad++;
            $display("FAIL write_pre_ready: ready=%b expected 1", cmd_ready);
        end
        cmd_valid = 1'b1;
        cmd_rs    = 1'b1;
        cmd_data  = 8'h41;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        for (int k = 0; k < 14; k++) begin
            if (k > 0) begin
                @(posedge clk); #1;
            end
            total++;
            if (lcd_en !== (k >= 2 && k <= 4) || cmd_ready !== (k >= 12) ||
                lcd_rs !== 1'b1 || lcd_data !== 8'h41) begin
                bad++;
                $display("FAIL write_cycle k=%0d: en=%b ready=%b rs=%b data=%h expected en=%b ready=%b rs=1 data=41",
                         k, lcd_en, cmd_ready, lcd_rs, lcd_data, (k >= 2 && k <= 4), (k >= 12));
            end
        end
        $display("test_data_write: data 0x41 written, ready back after 12 cycles");
    endtask

    task automatic test_back_to_back();
        int   rise_k [2];
        int   rises = 0;
        logic prev_en = 1'b0;
        cmd_valid = 1'b1;
        cmd_rs    = 1'b0;
        cmd_data  = 8'h01;
        @(posedge clk); #1;
        cmd_data = 8'h80;
        for (int k = 0; k < 42; k++) begin
            if (k > 0) begin
                @(posedge clk); #1;
            end
            total++;
            if (cmd_ready !== (k == 27 || k >= 40)) begin
                bad++;
                $display("FAIL b2b_ready k=%0d: ready=%b expected %b", k, cmd_ready, (k == 27 || k >= 40));
            end
            if (lcd_en === 1'b1 && prev_en === 1'b0) begin
                if (rises < 2) rise_k[rises] = k;
                rises++;
            end
            prev_en = lcd_en;
            if (k == 27 || k == 28) begin
                total++;
                if (lcd_data !== ((k == 27) ? 8'h01 : 8'h80) || lcd_rs !== 1'b0) begin
                    bad++;
                    $display("FAIL b2b_data k=%0d: data=%h rs=%b expected %h rs 0", k, lcd_data, lcd_rs,
                             (k == 27) ? 8'h01 : 8'h80);
                end
            end
            if (k == 28) cmd_valid = 1'b0;
        end
        total++;
        if (rises != 2 || rise_k[0] != 2 || rise_k[1] != 30) begin
            bad++;
            $display("FAIL b2b_en: %0d pulses at k=%0d,%0d expected 2 at k=2,30", rises, rise_k[0], rise_k[1]);
        end
        $display("test_back_to_back: 0x01 then 0x80 with long then short wait");
    endtask

    task automatic test_valid_ignored();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        run_init("ignore", 1'b0, 1'b1);
    endtask

    task automatic test_reset_mid();
        int waited = 0;
        ctl_on    = 1'b1;
        ctl_blon  = 1'b1;
        cmd_valid = 1'b1;
        cmd_rs    = 1'b1;
        cmd_data  = 8'h5A;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        while (lcd_en !== 1'b1 && waited < 10) begin
            @(posedge clk); #1;
            waited++;
        end
        total++;
        if (lcd_en !== 1'b1) begin
            bad++;
            $display("FAIL midrst_wait_en: en=%b after %0d cycles expected 1", lcd_en, waited);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        total++;
        if ({cmd_ready, init_done, lcd_on, lcd_blon, lcd_rs, lcd_rw, lcd_en, lcd_data} !== 15'd0) begin
            bad++;
            $display("FAIL midrst_outputs: rdy=%b done=%b on=%b blon=%b rs=%b rw=%b en=%b data=%h expected all 0",
                     cmd_ready, init_done, lcd_on, lcd_blon, lcd_rs, lcd_rw, lcd_en, lcd_data);
        end
        rst = 1'b0;
        run_init("reinit", 1'b0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_init_ctl();
        test_data_write();
        test_back_to_back();
        test_valid_ignored();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
